// File: rtl/ifu_prefetch.sv
// Instruction-fetch front end: owns the fetch PC, issues sequential credit-limited
// requests to instruction memory and buffers responses as {pc, instr} for decode.
module ifu_prefetch #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   count;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [XLEN-1:0] fifo_pc    [DEPTH];
    logic [31:0]     fifo_instr [DEPTH];

    logic [CW:0]     inflight;
    logic            req_fire;
    logic            rsp_fire;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] redirect_base;
    logic            unused_redirect_lsbs;

    assign redirect_base        = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Requests in flight plus buffered entries never exceed DEPTH, so the FIFO cannot overflow.
    assign inflight       = {1'b0, outstanding} + {1'b0, count};
    assign imem_req_valid = rst_n && (inflight < (CW + 1)'(DEPTH)) && !redirect_valid;
    assign imem_req_addr  = fetch_pc;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_fire = imem_rsp_valid && (outstanding != '0);
    assign push     = rsp_fire && (drop_cnt == '0) && !redirect_valid;

    assign out_valid = (count != '0) && !redirect_valid;
    assign pop       = out_valid && out_ready;
    assign out_pc    = (count != '0) ? fifo_pc[rd_ptr]    : '0;
    assign out_instr = (count != '0) ? fifo_instr[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight belongs to the old stream and must be discarded.
            fetch_pc    <= redirect_base;
            rsp_pc      <= redirect_base;
            outstanding <= outstanding - CW'(rsp_fire);
            drop_cnt    <= outstanding - CW'(rsp_fire);
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);
            if (rsp_fire && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            if (push) begin
                rsp_pc <= rsp_pc + XLEN'(4);
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= rsp_pc;
            fifo_instr[wr_ptr] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch: behavioural memory with fixed latency and a
// PC-sequence model that checks every instruction popped to decode.
module tb_ifu_prefetch;

    localparam int          XLEN   = 64;
    localparam int          DEPTH  = 4;
    localparam logic [63:0] RST_PC = 64'h8000_0000;
    localparam logic [63:0] W_BASE = 64'hFFFF_FFFF_FFFF_FFF8;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;

    logic        w_req_valid;
    logic [63:0] w_req_addr;
    logic        w_out_valid;
    logic [31:0] w_out_instr;
    logic [63:0] w_out_pc;

    ifu_prefetch #(.XLEN(XLEN), .RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc)
    );

    ifu_prefetch #(.XLEN(XLEN), .RESET_PC(W_BASE), .DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(w_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(w_out_valid), .out_ready(out_ready),
        .out_instr(w_out_instr), .out_pc(w_out_pc)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc;
    int          lat;
    int          n_acc;
    int          n_pop;
    int          max_q;
    int          pops_before;
    logic [63:0] exp_pc;
    logic [63:0] req_q[$];
    int          due_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: called at a negedge with inputs set; ends at the next negedge.
    task automatic cycle();
        #1;
        if (imem_req_valid && imem_req_ready) begin
            req_q.push_back(imem_req_addr);
            due_q.push_back(cyc + lat);
            n_acc++;
        end
        if (req_q.size() > max_q) max_q = req_q.size();
        if (out_valid && out_ready) begin
            n_pop++;
            chk("pop_pc", out_pc, exp_pc);
            chk("pop_instr", {32'h0, out_instr}, {32'h0, ~exp_pc[31:0]});
            exp_pc = exp_pc + 64'd4;
        end
        if (redirect_valid) exp_pc = {redirect_pc[63:2], 2'b00};
        @(posedge clk);
        cyc++;
        @(negedge clk);
        redirect_valid = 1'b0;
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ~req_q[0][31:0];
            void'(req_q.pop_front());
            void'(due_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        req_q.delete();
        due_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        cyc    = 0;
        exp_pc = RST_PC;
        n_acc  = 0;
        n_pop  = 0;
        max_q  = 0;
    endtask

    task automatic wait_valid(input int maxc);
        for (int k = 0; k < maxc; k++) begin
            #1;
            if (out_valid) break;
            cycle();
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        lat            = 1;
        @(negedge clk);
        #1;
        chk("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_req_addr", imem_req_addr, RST_PC);
        chk("rst_out_pc", out_pc, 64'h0);
        chk("rst_out_instr", {32'h0, out_instr}, 64'h0);

        // Streaming with 1-cycle memory; the second instance checks address wrap.
        do_reset();
        #1;
        chk("first_req_valid", imem_req_valid, 1'b1);
        chk("first_req_addr", imem_req_addr, RST_PC);
        for (int i = 0; i < 10; i++) begin
            chk("stream_out_valid", out_valid, (i >= 2) ? 1'b1 : 1'b0);
            chk("wrap_req_addr", w_req_addr, W_BASE + 64'(4 * i));
            if (i >= 2) chk("wrap_out_pc", w_out_pc, W_BASE + 64'(4 * (i - 2)));
            cycle();
            #1;
        end
        chk("stream_pops", n_pop, 8);
        chk("stream_max_inflight_ok", (max_q <= DEPTH) ? 1'b1 : 1'b0, 1'b1);

        // Backpressure: FIFO fills to DEPTH, then drains without loss or duplication.
        out_ready = 1'b0;
        do_reset();
        repeat (10) cycle();
        #1;
        chk("bp_req_valid", imem_req_valid, 1'b0);
        chk("bp_out_valid", out_valid, 1'b1);
        chk("bp_fill", n_acc - n_pop, 4);
        chk("bp_pending", req_q.size(), 0);
        out_ready = 1'b1;
        repeat (12) cycle();
        chk("bp_resume_pops", n_pop, 12);
        chk("bp_max_inflight_ok", (max_q <= DEPTH) ? 1'b1 : 1'b0, 1'b1);

        // Redirect with three requests in flight and no response in that cycle.
        lat = 4;
        do_reset();
        repeat (3) cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_1002;
        #1;
        chk("rd3_inflight", req_q.size(), 3);
        chk("rd3_req_valid", imem_req_valid, 1'b0);
        chk("rd3_out_valid", out_valid, 1'b0);
        cycle();
        wait_valid(30);
        chk("rd3_seen", out_valid, 1'b1);
        chk("rd3_first_pc", out_pc, 64'h8000_1000);
        chk("rd3_first_cycle", cyc, 9);
        repeat (6) cycle();

        // Redirect coinciding with a response while decode is ready.
        lat = 2;
        do_reset();
        repeat (5) cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_2000;
        #1;
        chk("rdr_rsp_present", imem_rsp_valid, 1'b1);
        chk("rdr_out_valid", out_valid, 1'b0);
        chk("rdr_req_valid", imem_req_valid, 1'b0);
        pops_before = n_pop;
        cycle();
        chk("rdr_no_pop", n_pop, pops_before);
        wait_valid(30);
        chk("rdr_seen", out_valid, 1'b1);
        chk("rdr_first_pc", out_pc, 64'h8000_2000);
        chk("rdr_first_cycle", cyc, 9);
        repeat (6) cycle();

        // Asynchronous reset mid-stream, then stray responses with no requests outstanding.
        lat = 3;
        do_reset();
        repeat (5) cycle();
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_req_valid", imem_req_valid, 1'b0);
        chk("ar_out_valid", out_valid, 1'b0);
        chk("ar_req_addr", imem_req_addr, RST_PC);
        chk("ar_out_pc", out_pc, 64'h0);
        chk("ar_out_instr", {32'h0, out_instr}, 64'h0);
        exp_pc = RST_PC;
        @(negedge clk);
        rst_n          = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        repeat (6) cycle();
        #1;
        chk("ar_stray_out_valid", out_valid, 1'b0);
        chk("ar_stray_req_addr", imem_req_addr, RST_PC);
        imem_req_ready = 1'b1;
        wait_valid(20);
        chk("ar_seen", out_valid, 1'b1);
        chk("ar_first_pc", out_pc, RST_PC);
        repeat (6) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
